// File: rtl/riviera_hazard_scoreboard_pkg.sv
// riviera_hazard_scoreboard_pkg: shared widths and slot type for the RAW-hazard scoreboard
package riviera_hazard_scoreboard_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int SB_DEPTH = 3;
  localparam int SB_SEL_W = $clog2(SB_DEPTH + 1);
  typedef struct packed {
    logic valid;
    logic [ADDR_W-1:0] rd;
    logic is_load;
  } sb_slot_t;
endpackage

// File: rtl/riviera_hazard_scoreboard_if.sv
// riviera_hazard_scoreboard_if: ID-side issue/source bus and scoreboard stall/forward results
interface riviera_hazard_scoreboard_if
  import riviera_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int SEL_W = SB_SEL_W
);
  logic issue_valid;
  logic issue_wr_en;
  logic [ADDR_W-1:0] issue_rd;
  logic issue_is_load;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC-1:0] src_used;
  logic advance;
  logic flush;
  logic stall;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic [NUM_REGS-1:0] pending;
  logic [2:0] inflight_cnt;
  modport master (
    output issue_valid, issue_wr_en, issue_rd, issue_is_load, src_addr, src_used, advance, flush,
    input stall, fwd_sel, pending, inflight_cnt
  );
  modport slave (
    input issue_valid, issue_wr_en, issue_rd, issue_is_load, src_addr, src_used, advance, flush,
    output stall, fwd_sel, pending, inflight_cnt
  );
endinterface

// File: rtl/riviera_hazard_scoreboard_sb_match.sv
// riviera_hazard_scoreboard_sb_match: youngest-slot match of one source register against the slots
module riviera_hazard_scoreboard_sb_match
  import riviera_hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  sb_slot_t [DEPTH-1:0] slots,
  input  logic [ADDR_W-1:0]    src,
  input  logic                 used,
  output logic                 hit,
  output logic [SEL_W-1:0]     idx,
  output logic                 is_load
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    is_load = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (used && src != '0 && slots[k].valid && slots[k].rd == src) begin
        hit = 1'b1;
        idx = SEL_W'(k);
        is_load = slots[k].is_load;
      end
  end
endmodule

// File: rtl/riviera_hazard_scoreboard.sv
// riviera_hazard_scoreboard: in-flight rd tracking, ID stall and EX forward select for the riviera pipeline
module riviera_hazard_scoreboard
  import riviera_hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int NUM_SRC = 2,
  parameter bit FWD_EN = 1'b1,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst_n,
  riviera_hazard_scoreboard_if.slave sb
);
  sb_slot_t [DEPTH-1:0] slots;
  sb_slot_t ins;
  logic [NUM_SRC-1:0] hit, ld, haz;
  logic [NUM_SRC-1:0][SEL_W-1:0] idx, sel;
  logic [NUM_REGS-1:0] pend;
  logic [2:0] cnt;
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    riviera_hazard_scoreboard_sb_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match (
      .slots(slots),
      .src(sb.src_addr[s*ADDR_W +: ADDR_W]),
      .used(sb.src_used[s]),
      .hit(hit[s]),
      .idx(idx[s]),
      .is_load(ld[s])
    );
  end
  always_comb begin
    sel = '0;
    haz = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      sel[s] = (FWD_EN && hit[s]) ? idx[s] + SEL_W'(1) : '0;
      haz[s] = FWD_EN ? hit[s] && ld[s] && idx[s] == '0 : hit[s];
    end
  end
  assign sb.stall = sb.issue_valid && !sb.flush && |haz;
  assign sb.fwd_sel = sel;
  assign ins.valid = sb.issue_valid && !sb.stall && !sb.flush && sb.issue_wr_en && sb.issue_rd != '0;
  assign ins.rd = sb.issue_rd;
  assign ins.is_load = sb.issue_is_load;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slots <= '0;
    else if (sb.advance) begin
      for (int k = DEPTH - 1; k > 0; k--) slots[k] <= slots[k-1];
      slots[0] <= ins;
    end
  always_comb begin
    pend = '0;
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slots[k].valid) pend[slots[k].rd] = 1'b1;
      cnt = cnt + 3'(slots[k].valid);
    end
  end
  assign sb.pending = pend;
  assign sb.inflight_cnt = cnt;
endmodule
